ctrl_barrido_teclado: RTL and testbench

Scan controller for the 4x4 matrix keypad. It sequences the one-hot row ring (fila) at a programmable dwell rate and samples the column lines. It debounces a press and encodes it to a key index, then presents that index to downstream logic over a valid/ack handshake. Release is also debounced before scanning resumes.

---
 rtl/ctrl_barrido_teclado.sv | 173 +++++++++++++++++
 tb/tb_ctrl_barrido_teclado.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_barrido_teclado.sv
// Scan controller for a WIDTH x COLS matrix keypad: rotates a one-hot row drive,
// debounces press and release, and hands the encoded key out on a valid/ack pair.
module ctrl_barrido_teclado #(
  parameter int WIDTH      = 4,
  parameter int COLS       = 4,
  parameter int SCAN_DIV   = 1000,
  parameter int DEB_CYCLES = 5000,
  parameter int CODE_W     = $clog2(WIDTH*COLS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [COLS-1:0]   columna,
  input  logic              tecla_ack,
  output logic [WIDTH-1:0]  fila,
  output logic [CODE_W-1:0] tecla,
  output logic              tecla_valida,
  output logic              tecla_overrun
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int DEB_W = $clog2(DEB_CYCLES + 1);

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCAN_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ZERO  = DIV_W'(0);
  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);
  localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [DEB_W-1:0] DEB_ZERO  = DEB_W'(0);
  localparam logic [DEB_W-1:0] DEB_ONE   = DEB_W'(1);
  localparam logic [COLS-1:0]  COL_ZERO  = {COLS{1'b0}};
  localparam logic [WIDTH-1:0] FILA_INIT = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    SCAN      = 3'd0,
    DEB_PRESS = 3'd1,
    EMIT      = 3'd2,
    WAIT_REL  = 3'd3,
    DEB_REL   = 3'd4
  } state_t;

  state_t            state_r;
  logic [DIV_W-1:0]  div_cnt_r;
  logic [DEB_W-1:0]  deb_cnt_r;
  logic [COLS-1:0]   col_meta_r;
  logic [COLS-1:0]   col_sync_r;
  logic [COLS-1:0]   col_cap_r;
  logic [WIDTH-1:0]  fila_next_s;

  // Row index of the active row times COLS plus the lowest pressed column.
  function automatic logic [CODE_W-1:0] encode(input logic [WIDTH-1:0] f,
                                               input logic [COLS-1:0]  c);
    int r;
    int k;
    r = 0;
    k = 0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (f[i]) r = i;
    end
    for (int j = COLS - 1; j >= 0; j--) begin
      if (c[j]) k = j;
    end
    encode = CODE_W'(r * COLS + k);
  endfunction

  assign fila_next_s = {fila[WIDTH-2:0], fila[WIDTH-1]};

  // Two-flop synchronizer for the asynchronous column lines.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_meta_r <= COL_ZERO;
      col_sync_r <= COL_ZERO;
    end else begin
      col_meta_r <= columna;
      col_sync_r <= col_meta_r;
    end
  end

  // Scan/debounce FSM with the output handshake registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= SCAN;
      div_cnt_r     <= DIV_ZERO;
      deb_cnt_r     <= DEB_ZERO;
      col_cap_r     <= COL_ZERO;
      fila          <= FILA_INIT;
      tecla         <= {CODE_W{1'b0}};
      tecla_valida  <= 1'b0;
      tecla_overrun <= 1'b0;
    end else begin
      tecla_overrun <= 1'b0;
      if (tecla_valida && tecla_ack) begin
        tecla_valida <= 1'b0;
      end else begin
        tecla_valida <= tecla_valida;
      end

      case (state_r)
        SCAN: begin
          if (div_cnt_r == DIV_LAST) begin
            div_cnt_r <= DIV_ZERO;
            if (col_sync_r == COL_ZERO) begin
              fila <= fila_next_s;
            end else begin
              col_cap_r <= col_sync_r;
              deb_cnt_r <= DEB_ZERO;
              state_r   <= DEB_PRESS;
            end
          end else begin
            div_cnt_r <= div_cnt_r + DIV_ONE;
          end
        end

        DEB_PRESS: begin
          if (col_sync_r == col_cap_r) begin
            if (deb_cnt_r == DEB_LAST) begin
              deb_cnt_r <= DEB_ZERO;
              state_r   <= EMIT;
            end else begin
              deb_cnt_r <= deb_cnt_r + DEB_ONE;
            end
          end else begin
            // A bounce aborts the press; the same row gets a fresh dwell.
            deb_cnt_r <= DEB_ZERO;
            div_cnt_r <= DIV_ZERO;
            state_r   <= SCAN;
          end
        end

        EMIT: begin
          if (!tecla_valida || tecla_ack) begin
            tecla        <= encode(fila, col_cap_r);
            tecla_valida <= 1'b1;
          end else begin
            tecla_overrun <= 1'b1;
          end
          state_r <= WAIT_REL;
        end

        WAIT_REL: begin
          if (col_sync_r == COL_ZERO) begin
            deb_cnt_r <= DEB_ZERO;
            state_r   <= DEB_REL;
          end else begin
            state_r <= WAIT_REL;
          end
        end

        DEB_REL: begin
          if (col_sync_r == COL_ZERO) begin
            if (deb_cnt_r == DEB_LAST) begin
              deb_cnt_r <= DEB_ZERO;
              div_cnt_r <= DIV_ZERO;
              fila      <= fila_next_s;
              state_r   <= SCAN;
            end else begin
              deb_cnt_r <= deb_cnt_r + DEB_ONE;
            end
          end else begin
            deb_cnt_r <= DEB_ZERO;
            state_r   <= WAIT_REL;
          end
        end

        default: begin
          state_r   <= SCAN;
          div_cnt_r <= DIV_ZERO;
          deb_cnt_r <= DEB_ZERO;
          fila      <= FILA_INIT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_barrido_teclado.sv
// Bench for ctrl_barrido_teclado: keypad model drives columna from fila, a
// scoreboard queue holds expected keys and a monitor pops them on each handshake.
module tb_ctrl_barrido_teclado;

  logic       clk;
  logic       rst;
  logic [3:0] columna;
  logic       tecla_ack;
  logic [3:0] fila;
  logic [3:0] tecla;
  logic       tecla_valida;
  logic       tecla_overrun;

  logic       press_on;
  int         press_row;
  logic [3:0] press_mask;
  logic [3:0] glitch;
  logic       auto_ack;
  logic       ack_auto;
  logic       ack_man;
  logic       prev_ovr;

  int checks;
  int errors;
  int ovr_seen;
  int exp_q[$];
  int ovr_q[$];

  ctrl_barrido_teclado #(
    .WIDTH(4), .COLS(4), .SCAN_DIV(4), .DEB_CYCLES(3)
  ) dut (
    .clk(clk), .rst(rst), .columna(columna), .tecla_ack(tecla_ack),
    .fila(fila), .tecla(tecla), .tecla_valida(tecla_valida),
    .tecla_overrun(tecla_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad: a held key connects its column lines only while its row is driven.
  always_comb begin
    columna = glitch | ((press_on && fila[press_row]) ? press_mask : 4'b0000);
  end

  assign tecla_ack = auto_ack ? ack_auto : ack_man;

  always @(negedge clk) begin
    ack_auto = auto_ack && tecla_valida && ($urandom_range(0, 1) == 1);
  end

  task automatic chk(input string nm, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
    end
  endtask

  function automatic int key_code(input int row, input logic [3:0] mask);
    int col;
    col = 0;
    for (int j = 3; j >= 0; j--) if (mask[j]) col = j;
    return row * 4 + col;
  endfunction

  // Monitor: one-hot check, scoreboard pop on handshake, overrun accounting.
  always @(negedge clk) begin
    #2;
    if (rst) begin
      prev_ovr = 1'b0;
    end else begin
      chk("fila_onehot", $countones(fila), 1);
      if (tecla_valida && tecla_ack) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tecla_unexpected got=%0d expected=none", tecla);
        end else begin
          chk("tecla", int'(tecla), exp_q.pop_front());
        end
      end
      if (tecla_overrun) begin
        ovr_seen++;
        checks++;
        if (prev_ovr || ovr_q.size() == 0) begin
          errors++;
          $display("FAIL overrun got=pulse prev=%0d pending=%0d expected=single_expected_pulse",
                   prev_ovr, ovr_q.size());
        end else begin
          void'(ovr_q.pop_front());
        end
      end
      prev_ovr = tecla_overrun;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic press(input int row, input logic [3:0] mask);
    press_row  = row;
    press_mask = mask;
    press_on   = 1'b1;
  endtask

  task automatic wait_fila(input string nm, input logic [3:0] v, input int lim);
    int n;
    n = 0;
    while (fila !== v && n < lim) begin
      tick();
      n++;
    end
    chk(nm, fila, v);
  endtask

  task automatic wait_valid(input string nm, input int lim);
    int n;
    n = 0;
    while (tecla_valida !== 1'b1 && n < lim) begin
      tick();
      n++;
    end
    chk(nm, tecla_valida, 1);
  endtask

  task automatic ack_pulse(input string nm);
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    chk(nm, tecla_valida, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int target;
    int row;
    int n;
    logic [3:0] mask;
    checks = 0; errors = 0; ovr_seen = 0;
    press_on = 1'b0; press_row = 0; press_mask = 4'b0000; glitch = 4'b0000;
    auto_ack = 1'b0; ack_man = 1'b0; prev_ovr = 1'b0;

    // Idle scan: each row held exactly 4 cycles, no key.
    do_reset();
    chk("rst_tecla", tecla, 0);
    chk("rst_overrun", tecla_overrun, 0);
    for (int i = 0; i < 20; i++) begin
      chk("scan_fila", fila, 1 << ((i / 4) % 4));
      chk("scan_valid", tecla_valida, 0);
      tick();
    end

    // Short glitch on row 0: press aborted, row 0 gets a fresh dwell.
    do_reset();
    tick();
    glitch = 4'b0001;
    tick();
    tick();
    glitch = 4'b0000;
    repeat (4) tick();
    chk("glitch_row_kept", fila, 4'b0001);
    repeat (3) tick();
    chk("glitch_row_next", fila, 4'b0010);
    chk("glitch_no_key", tecla_valida, 0);

    // Key 9 held without ack, release debounce, then overrun on key 0.
    exp_q.push_back(9);
    press(2, 4'b0010);
    wait_valid("key9_valid", 40);
    repeat (5) tick();
    chk("key9_hold_valid", tecla_valida, 1);
    chk("key9_hold_tecla", tecla, 9);
    press_on = 1'b0;
    repeat (4) tick();
    chk("release_frozen", fila, 4'b0100);
    wait_fila("release_resume", 4'b1000, 15);
    ovr_q.push_back(1);
    target = ovr_seen + 1;
    press(0, 4'b0001);
    n = 0;
    while (ovr_seen < target && n < 40) begin
      tick();
      n++;
    end
    chk("overrun_seen", ovr_seen, target);
    chk("overrun_tecla_kept", tecla, 9);
    chk("overrun_valid_kept", tecla_valida, 1);
    press_on = 1'b0;
    wait_fila("overrun_release", 4'b0010, 30);
    ack_pulse("ack9_clears");

    // Key 9 again, then key 0 with ack landing in the emit cycle.
    exp_q.push_back(9);
    press(2, 4'b0010);
    wait_valid("key9b_valid", 40);
    press_on = 1'b0;
    wait_fila("key9b_release", 4'b1000, 15);
    exp_q.push_back(0);
    press(0, 4'b0001);
    wait_fila("key0_row", 4'b0001, 10);
    repeat (7) tick();
    ack_man = 1'b1;
    tick();
    ack_man = 1'b0;
    chk("emit_ack_tecla", tecla, 0);
    chk("emit_ack_valid", tecla_valida, 1);
    chk("emit_ack_no_ovr", tecla_overrun, 0);
    press_on = 1'b0;
    wait_fila("key0_release", 4'b0010, 30);
    ack_pulse("ack0_clears");

    // Two columns on row 3 resolve to the lower column; then random keys.
    auto_ack = 1'b1;
    exp_q.push_back(key_code(3, 4'b1010));
    press(3, 4'b1010);
    repeat (26) tick();
    press_on = 1'b0;
    repeat (10) tick();
    for (int k = 0; k < 12; k++) begin
      row  = int'($urandom_range(0, 3));
      mask = 4'($urandom_range(1, 15));
      exp_q.push_back(key_code(row, mask));
      press(row, mask);
      repeat (26) tick();
      press_on = 1'b0;
      repeat (8 + $urandom_range(0, 6)) tick();
    end
    n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      tick();
      n++;
    end
    chk("drain_keys", exp_q.size(), 0);

    // Reset in the middle of press debounce.
    press(0, 4'b0100);
    do_reset();
    repeat (4) tick();
    rst = 1'b1;
    tick();
    press_on = 1'b0;
    chk("rstdeb_fila", fila, 4'b0001);
    chk("rstdeb_valid", tecla_valida, 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("rstdeb_scan", fila, 1 << (i / 4));
      chk("rstdeb_novalid", tecla_valida, 0);
      tick();
    end

    // Reset while a key is pending: the key is lost.
    auto_ack = 1'b0;
    exp_q.push_back(key_code(1, 4'b0100));
    press(1, 4'b0100);
    wait_valid("key6_valid", 40);
    rst = 1'b1;
    exp_q.delete();
    press_on = 1'b0;
    tick();
    chk("rstval_fila", fila, 4'b0001);
    chk("rstval_tecla", tecla, 0);
    chk("rstval_valid", tecla_valida, 0);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("rstval_scan", fila, 1 << (i / 4));
      tick();
    end

    chk("final_exp_q", exp_q.size(), 0);
    chk("final_ovr_q", ovr_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
